// File: rtl/cordic_op_sequencer.sv
// Serialises one CORDIC command (func, op1, op2) onto Top's shared sw_in bus with st strobes.
// Optional SKIP_SINGLE_OP_EN: single-operand functions skip the OP2 phase.
module cordic_op_sequencer #(
  parameter int unsigned      DW          = 16,
  parameter int unsigned      FW          = 4,
  parameter int unsigned      HOLD        = 70,
  parameter logic [2**FW-1:0] TWO_OP_MASK = 16'h0083
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [FW-1:0] cmd_func,
  input  logic [DW-1:0] cmd_op1,
  input  logic [DW-1:0] cmd_op2,
  input  logic          abort,
  output logic          st,
  output logic [DW-1:0] sw_in,
  output logic          busy,
  output logic          done
);

  localparam int unsigned    CW       = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD);
  localparam logic [CW-1:0] HoldPrev = CW'(HOLD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFunc,
    StOp1,
    StOp2,
    StGo,
    StResult
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          st_q;
  logic          done_q;
  logic [DW-1:0] sw_in_q;
  logic [DW-1:0] op1_q;
  logic [DW-1:0] op2_q;

`ifdef SKIP_SINGLE_OP_EN
  logic two_op_q;
`else
  // Operand count only matters when OP2 can be skipped.
  logic unused_two_op;
  assign unused_two_op = TWO_OP_MASK[cmd_func];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      st_q     <= 1'b0;
      done_q   <= 1'b0;
      sw_in_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
`ifdef SKIP_SINGLE_OP_EN
      two_op_q <= 1'b0;
`endif
    end else begin
      st_q   <= 1'b0;
      done_q <= 1'b0;
      if (state_q == StIdle) begin
        cnt_q <= '0;
        if (cmd_valid) begin
          state_q  <= StFunc;
          op1_q    <= cmd_op1;
          op2_q    <= cmd_op2;
          sw_in_q  <= DW'(cmd_func);
`ifdef SKIP_SINGLE_OP_EN
          two_op_q <= TWO_OP_MASK[cmd_func];
`endif
        end
      end else if (abort) begin
        // Abort wins over phase completion; sw_in deliberately keeps its value.
        state_q <= StIdle;
        cnt_q   <= '0;
      end else if (cnt_q == HoldLast) begin
        cnt_q <= '0;
        case (state_q)
          StFunc: begin
            state_q <= StOp1;
            sw_in_q <= op1_q;
          end
          StOp1: begin
`ifdef SKIP_SINGLE_OP_EN
            if (two_op_q) begin
              state_q <= StOp2;
              sw_in_q <= op2_q;
            end else begin
              state_q <= StGo;
            end
`else
            state_q <= StOp2;
            sw_in_q <= op2_q;
`endif
          end
          StOp2:    state_q <= StGo;
          StGo:     state_q <= StResult;
          StResult: begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
          default:  state_q <= StIdle;
        endcase
      end else begin
        cnt_q <= cnt_q + 1'b1;
        // Registered strobe lands exactly on the phase's last cycle.
        st_q  <= (cnt_q == HoldPrev);
      end
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign st        = st_q;
  assign done      = done_q;
  assign sw_in     = sw_in_q;

endmodule

// File: tb/tb_cordic_op_sequencer.sv
// Scoreboard bench for cordic_op_sequencer: HOLD=3 instance (main) and HOLD=1 instance (boundary).
module tb_cordic_op_sequencer;

  localparam int H0 = 3;
  localparam int H1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          cyc;
    bit          kind;  // 0: st strobe, 1: done pulse
    logic [15:0] sw;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];
  int   busy_from = 0;
  int   idle_from = 0;
  bit   dut1_fin  = 1'b0;

  // Main instance
  logic        rst_n, cmd_valid, cmd_ready, abort, st, busy, done;
  logic [3:0]  cmd_func;
  logic [15:0] cmd_op1, cmd_op2, sw_in;

  cordic_op_sequencer #(.DW(16), .FW(4), .HOLD(H0), .TWO_OP_MASK(16'h0083)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .abort(abort),
    .st(st), .sw_in(sw_in), .busy(busy), .done(done)
  );

  // Minimum-HOLD instance
  logic        rst1_n, v1, rdy1, ab1, st1, busy1, done1;
  logic [3:0]  f1;
  logic [15:0] a1, b1, sw1;

  cordic_op_sequencer #(.DW(16), .FW(4), .HOLD(H1), .TWO_OP_MASK(16'h0083)) dut1 (
    .clk(clk), .rst_n(rst1_n), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_func(f1), .cmd_op1(a1), .cmd_op2(b1), .abort(ab1),
    .st(st1), .sw_in(sw1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: expected strobes/done for a command accepted at cycle acc.
  function automatic int plan(input bit which, input int h, input int acc, input logic [3:0] f,
                              input logic [15:0] a, input logic [15:0] b);
    logic [15:0] vals [5];
    int          nph;
    evt_t        e;
    vals = '{16'(f), a, b, b, b};
    nph  = 5;
`ifdef SKIP_SINGLE_OP_EN
    if (!(f == 4'd0 || f == 4'd1 || f == 4'd7)) begin
      vals = '{16'(f), a, a, a, a};
      nph  = 4;
    end
`endif
    for (int p = 0; p < nph; p++) begin
      e.cyc  = acc + (p + 1) * (h + 1);
      e.kind = 1'b0;
      e.sw   = vals[p];
      if (which) q1.push_back(e); else q0.push_back(e);
    end
    e.cyc  = acc + nph * (h + 1) + 1;
    e.kind = 1'b1;
    e.sw   = vals[nph-1];
    if (which) q1.push_back(e); else q0.push_back(e);
    return e.cyc;
  endfunction

  // Monitor: main instance
  always @(negedge clk) begin
    bit   eb;
    evt_t e;
    if (rst_n) begin
      eb = (cyc >= busy_from) && (cyc < idle_from);
      check("busy", busy, eb);
      check("cmd_ready", cmd_ready, !eb);
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
        check(q0[0].kind ? "done_missing_at" : "st_missing_at", cyc, q0[0].cyc);
        void'(q0.pop_front());
      end
      if (st || done) begin
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
          e = q0.pop_front();
          check("pulse_kind", {st, done}, e.kind ? 2'b01 : 2'b10);
          check("sw_in", sw_in, e.sw);
        end else begin
          check("unexpected_pulse", {st, done}, 2'b00);
        end
      end
    end
  end

  // Monitor: HOLD=1 instance
  always @(negedge clk) begin
    evt_t e;
    if (rst1_n) begin
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        check(q1[0].kind ? "h1_done_missing_at" : "h1_st_missing_at", cyc, q1[0].cyc);
        void'(q1.pop_front());
      end
      if (st1 || done1) begin
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
          e = q1.pop_front();
          check("h1_pulse_kind", {st1, done1}, e.kind ? 2'b01 : 2'b10);
          check("h1_sw_in", sw1, e.sw);
        end else begin
          check("h1_unexpected_pulse", {st1, done1}, 2'b00);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input bit ab_idle, output int acc, output int dc);
    int n;
    n         = 0;
    cmd_valid = 1'b1;
    cmd_func  = f;
    cmd_op1   = a;
    cmd_op2   = b;
    abort     = ab_idle;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("accept_timeout", cmd_ready, 1'b1);
    acc       = cyc;
    dc        = plan(1'b0, H0, acc, f, a, b);
    busy_from = acc + 1;
    idle_from = dc;
    tick();
    abort = 1'b0;
  endtask

  task automatic scramble();
    cmd_valid = 1'b0;
    cmd_func  = 4'($urandom);
    cmd_op1   = 16'($urandom);
    cmd_op2   = 16'($urandom);
  endtask

  task automatic do_abort(input int c);
    while (cyc < c) tick();
    abort = 1'b1;
    while (q0.size() > 0 && q0[$].cyc > c) void'(q0.pop_back());
    idle_from = c + 1;
    tick();
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < idle_from && n < 400) begin
      tick();
      n++;
    end
    if (cyc < idle_from) check("idle_timeout", cyc, idle_from);
  endtask

  task automatic run(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                     input bit ab_idle, input int abort_off);
    int acc, dc;
    issue(f, a, b, ab_idle, acc, dc);
    scramble();
    if (abort_off > 0) do_abort(acc + abort_off);
    wait_idle();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    int acc1, dc1, acc2, dc2, n;
    rst_n = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_func = '0; cmd_op1 = '0; cmd_op2 = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_st", st, 1'b0);
    check("rst_sw_in", sw_in, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run(4'd1, 16'h4000, 16'h2A9B, 1'b0, 0);
    run(4'd3, 16'($urandom), 16'($urandom), 1'b0, 0);
    run(4'd7, 16'($urandom), 16'($urandom), 1'b1, 0);  // abort while idle is ignored

    // Back-to-back: valid held high, second command taken in the done cycle
    issue(4'd0, 16'($urandom), 16'($urandom), 1'b0, acc1, dc1);
    cmd_func = 4'd9;
    cmd_op1  = 16'($urandom);
    cmd_op2  = 16'($urandom);
    issue(cmd_func, cmd_op1, cmd_op2, 1'b0, acc2, dc2);
    check("b2b_accept_cycle", acc2, dc1);
    scramble();
    wait_idle();

    run(4'd2, 16'($urandom), 16'($urandom), 1'b0, 6);  // abort in OP1, counter=1
    run(4'd2, 16'($urandom), 16'($urandom), 1'b0, 0);
    run(4'd0, 16'($urandom), 16'($urandom), 1'b0, 1);  // abort on first FUNC cycle
    run(4'd1, 16'($urandom), 16'($urandom), 1'b0, 20); // abort on last RESULT cycle
    run(4'd5, 16'($urandom), 16'($urandom), 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      run(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0);
    end

    // Async reset while st is high
    issue(4'd5, 16'($urandom), 16'($urandom), 1'b0, acc1, dc1);
    scramble();
    n = 0;
    while (!st && n < 50) begin
      tick();
      n++;
    end
    #1 rst_n = 1'b0;
    q0.delete();
    busy_from = 0;
    idle_from = 0;
    #1;
    check("midrst_st", st, 1'b0);
    check("midrst_sw_in", sw_in, 16'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run(4'd1, 16'($urandom), 16'($urandom), 1'b0, 0);

    n = 0;
    while (!dut1_fin && n < 1000) begin
      tick();
      n++;
    end
    if (!dut1_fin) check("h1_timeout", dut1_fin, 1'b1);
    tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int acc, dc, n;
    rst1_n = 1'b1; v1 = 1'b0; ab1 = 1'b0; f1 = '0; a1 = '0; b1 = '0;
    #1 rst1_n = 1'b0;
    tick();
    tick();
    rst1_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      v1 = 1'b1;
      f1 = (i == 0) ? 4'd7 : 4'($urandom);
      a1 = 16'($urandom);
      b1 = 16'($urandom);
      n  = 0;
      while (!rdy1 && n < 100) begin
        tick();
        n++;
      end
      if (!rdy1) check("h1_accept_timeout", rdy1, 1'b1);
      acc = cyc;
      dc  = plan(1'b1, H1, acc, f1, a1, b1);
      tick();
      v1 = 1'b0;
      f1 = 4'($urandom);
      a1 = 16'($urandom);
      b1 = 16'($urandom);
      n  = 0;
      while (cyc < dc && n < 100) begin
        tick();
        n++;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    dut1_fin = 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
